// File: rtl/falafel_config_regfile.sv
// rtl/falafel_config_regfile.sv - allocator config register file with shadow/active banks and commit FSM
// Bus writes land in shadow; an accepted COMMIT write copies shadow to active once the core is idle.
module falafel_config_regfile #(
  parameter int                         DATA_W      = 64,
  parameter int                         NUM_REGS    = 4,
  parameter logic [DATA_W-1:0]          ADDR_BASE   = '0,
  parameter int                         ADDR_STRIDE = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [DATA_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic                         rsp_err_o,
  input  logic                         core_idle_i,
  output logic                         commit_pending_o,
  output logic [NUM_REGS*DATA_W-1:0]   config_o
);

  localparam int                SHIFT       = $clog2(ADDR_STRIDE);
  localparam logic [DATA_W-1:0] STRIDE_MASK = DATA_W'(ADDR_STRIDE - 1);
  localparam logic [DATA_W-1:0] COMMIT_IDX  = DATA_W'(NUM_REGS);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t            state;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] reg_idx;
  logic [DATA_W-1:0] rd_data;
  logic              hit_reg;
  logic              hit_commit;
  logic              ro_hit;
  logic              accept;
  logic              shadow_we;

  assign req_ready_o      = !rsp_valid_o || rsp_ready_i;
  assign accept           = req_valid_i && req_ready_o;
  assign commit_pending_o = (state == ST_PENDING);

  // The extra top bit of diff is the borrow, i.e. the address sits below ADDR_BASE.
  always_comb begin
    diff       = {1'b0, req_addr_i} - {1'b0, ADDR_BASE};
    reg_idx    = diff[DATA_W-1:0] >> SHIFT;
    hit_reg    = 1'b0;
    hit_commit = 1'b0;
    if (!diff[DATA_W] && ((diff[DATA_W-1:0] & STRIDE_MASK) == '0)) begin
      hit_reg    = (reg_idx < COMMIT_IDX);
      hit_commit = (reg_idx == COMMIT_IDX);
    end
    rd_data = '0;
    ro_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_idx == DATA_W'(i)) begin
        rd_data = shadow[i];
        ro_hit  = RO_MASK[i];
      end
    end
    shadow_we = accept && req_write_i && hit_reg && !ro_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        active[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      // Apply copies the pre-edge shadow, so a write landing on this edge waits for the next commit.
      if (state == ST_PENDING && core_idle_i) begin
        for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
        state <= ST_IDLE;
      end else if (accept && req_write_i && hit_commit) begin
        state <= ST_PENDING;
      end

      for (int i = 0; i < NUM_REGS; i++) begin
        if (shadow_we && reg_idx == DATA_W'(i)) shadow[i] <= req_data_i;
      end

      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= '0;
        rsp_err_o   <= 1'b0;
        if (hit_reg) begin
          if (req_write_i) rsp_err_o  <= ro_hit;
          else             rsp_data_o <= rd_data;
        end else if (hit_commit) begin
          if (!req_write_i) rsp_data_o <= {{(DATA_W-1){1'b0}}, commit_pending_o};
        end else begin
          rsp_err_o <= 1'b1;
        end
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        rsp_data_o  <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign config_o[g*DATA_W +: DATA_W] = active[g];
  end

endmodule

// File: tb/tb_falafel_config_regfile.sv
// tb/tb_falafel_config_regfile.sv - bench for falafel_config_regfile
// Two instances share stimulus: u_dut has register 1 read-only, u_rw has every register writable.
module tb_falafel_config_regfile;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam logic [DW-1:0]    BASE = 64'h100;
  localparam logic [NR*DW-1:0] RV   = {64'hDDDD_0003, 64'hCCCC_0002, 64'hBBBB_0001, 64'hAAAA_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1, core_idle = 1'b0;
  logic [DW-1:0] req_addr = '0, req_data = '0;
  logic req_ready [2];
  logic rsp_valid [2];
  logic rsp_err [2];
  logic pend [2];
  logic [DW-1:0] rsp_data [2];
  logic [NR*DW-1:0] cfg [2];

  always #5 clk = ~clk;

  falafel_config_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_BASE(BASE), .ADDR_STRIDE(8),
                           .RO_MASK(4'b0010), .RESET_VAL(RV)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[0]),
    .rsp_err_o(rsp_err[0]), .core_idle_i(core_idle), .commit_pending_o(pend[0]), .config_o(cfg[0]));

  falafel_config_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_BASE(BASE), .ADDR_STRIDE(8),
                           .RO_MASK(4'b0000), .RESET_VAL(RV)) u_rw (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[1]),
    .rsp_err_o(rsp_err[1]), .core_idle_i(core_idle), .commit_pending_o(pend[1]), .config_o(cfg[1]));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_shadow [2][NR];
  logic [DW-1:0] m_active [2][NR];
  bit            m_pend;
  bit            m_rsp_valid;
  logic [DW-1:0] m_rsp_data [2];
  bit            m_rsp_err [2];

  function automatic logic [NR*DW-1:0] m_cfg(int k);
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_active[k][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        m_shadow[k][i] = RV[i*DW +: DW];
        m_active[k][i] = RV[i*DW +: DW];
      end
      m_rsp_data[k] = '0;
      m_rsp_err[k]  = 1'b0;
    end
    m_pend      = 1'b0;
    m_rsp_valid = 1'b0;
  endtask

  // One clock of the reference model: decode by arithmetic on the byte address, then update.
  task automatic step();
    bit acc, pend_pre;
    int kind, idx;
    logic [DW-1:0] off;
    acc      = req_valid && (!m_rsp_valid || rsp_ready);
    pend_pre = m_pend;
    kind     = 2;
    idx      = 0;
    if (req_addr >= BASE && (req_addr - BASE) % 8 == 0) begin
      off = (req_addr - BASE) / 8;
      if (off < NR) begin kind = 0; idx = int'(off); end
      else if (off == NR) kind = 1;
    end
    @(posedge clk); #1;
    if (pend_pre && core_idle) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < NR; i++) m_active[k][i] = m_shadow[k][i];
      m_pend = 1'b0;
    end
    if (acc) begin
      m_rsp_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_rsp_data[k] = '0;
        m_rsp_err[k]  = 1'b0;
        if (kind == 2) m_rsp_err[k] = 1'b1;
        else if (kind == 1) begin
          if (req_write) begin if (!pend_pre) m_pend = 1'b1; end
          else m_rsp_data[k] = pend_pre ? 64'd1 : 64'd0;
        end else if (req_write) begin
          if (k == 0 && idx == 1) m_rsp_err[k] = 1'b1;
          else m_shadow[k][idx] = req_data;
        end else m_rsp_data[k] = m_shadow[k][idx];
      end
    end else if (rsp_ready) m_rsp_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    core_idle = 1'b0; rsp_ready = 1'b1;
    do_req(1'b1, BASE, 64'h1234);
    do_req(1'b1, BASE + 32, 64'h0);
    rsp_ready = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid inst%0d got %b exp 0", k, rsp_valid[k]); end
      checks++; if (rsp_data[k] !== '0) begin errors++; $display("FAIL rst_rsp_data inst%0d got %h exp 0", k, rsp_data[k]); end
      checks++; if (rsp_err[k] !== 1'b0) begin errors++; $display("FAIL rst_rsp_err inst%0d got %b exp 0", k, rsp_err[k]); end
      checks++; if (pend[k] !== 1'b0) begin errors++; $display("FAIL rst_pending inst%0d got %b exp 0", k, pend[k]); end
      checks++; if (cfg[k] !== RV) begin errors++; $display("FAIL rst_config inst%0d got %h exp %h", k, cfg[k], RV); end
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL rst_req_ready inst%0d got %b exp 1", k, req_ready[k]); end
    end
    do_req(1'b0, BASE + 8, 64'h0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== 64'hBBBB_0001 || rsp_err[k] !== 1'b0) begin
        errors++; $display("FAIL rst_read_reg1 inst%0d got v%b %h e%b exp v1 bbbb0001 e0", k, rsp_valid[k], rsp_data[k], rsp_err[k]); end
    end
  endtask

  task automatic test_commit();
    core_idle = 1'b0;
    do_req(1'b1, BASE, 64'h1000);
    do_req(1'b1, BASE + 16, 64'hAB);
    do_req(1'b0, BASE, 64'h0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_data[k] !== 64'h1000) begin errors++; $display("FAIL commit_rd_reg0 inst%0d got %h exp 1000", k, rsp_data[k]); end
    end
    do_req(1'b0, BASE + 16, 64'h0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_data[k] !== 64'hAB) begin errors++; $display("FAIL commit_rd_reg2 inst%0d got %h exp ab", k, rsp_data[k]); end
      checks++; if (cfg[k] !== RV) begin errors++; $display("FAIL commit_cfg_before inst%0d got %h exp %h", k, cfg[k], RV); end
    end
    do_req(1'b1, BASE + 32, 64'hFFFF);
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++; if (pend[k] !== 1'b1 || cfg[k] !== RV) begin
          errors++; $display("FAIL commit_held c%0d inst%0d got pend %b cfg %h exp pend 1 cfg %h", c, k, pend[k], cfg[k], RV); end
      end
      step();
    end
    core_idle = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (cfg[k][0 +: DW] !== 64'h1000 || cfg[k][2*DW +: DW] !== 64'hAB || pend[k] !== 1'b0) begin
        errors++; $display("FAIL commit_apply inst%0d got r0 %h r2 %h pend %b exp r0 1000 r2 ab pend 0", k, cfg[k][0 +: DW], cfg[k][2*DW +: DW], pend[k]); end
      checks++; if (cfg[k] !== m_cfg(k)) begin errors++; $display("FAIL commit_apply_all inst%0d got %h exp %h", k, cfg[k], m_cfg(k)); end
    end
    core_idle = 1'b0;
  endtask

  task automatic test_errors();
    logic [DW-1:0] bad [4];
    bad[0] = BASE + 4; bad[1] = BASE + (NR + 1) * 8; bad[2] = BASE - 8; bad[3] = BASE + 13;
    for (int i = 0; i < 4; i++) begin
      do_req(1'(i % 2), bad[i], 64'hDEAD);
      for (int k = 0; k < 2; k++) begin
        checks++; if (rsp_err[k] !== 1'b1 || rsp_data[k] !== '0) begin
          errors++; $display("FAIL err_addr%0d inst%0d got e%b %h exp e1 0", i, k, rsp_err[k], rsp_data[k]); end
        checks++; if (pend[k] !== 1'b0 || cfg[k] !== m_cfg(k)) begin
          errors++; $display("FAIL err_state%0d inst%0d got pend %b cfg %h exp pend 0 cfg %h", i, k, pend[k], cfg[k], m_cfg(k)); end
      end
    end
    do_req(1'b1, BASE + 8, 64'h77);
    checks++; if (rsp_err[0] !== 1'b1 || rsp_data[0] !== '0) begin errors++; $display("FAIL err_ro_write got e%b %h exp e1 0", rsp_err[0], rsp_data[0]); end
    checks++; if (rsp_err[1] !== 1'b0) begin errors++; $display("FAIL err_rw_write got e%b exp e0", rsp_err[1]); end
    do_req(1'b0, BASE + 8, 64'h0);
    checks++; if (rsp_data[0] !== 64'hBBBB_0001) begin errors++; $display("FAIL err_ro_unchanged got %h exp bbbb0001", rsp_data[0]); end
    checks++; if (rsp_data[1] !== 64'h77) begin errors++; $display("FAIL err_rw_written got %h exp 77", rsp_data[1]); end
    do_req(1'b0, BASE, 64'h0);
    checks++; if (rsp_data[0] !== 64'h1000) begin errors++; $display("FAIL err_reg0_intact got %h exp 1000", rsp_data[0]); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] addrs [3];
    logic [DW-1:0] expv [3];
    logic [DW-1:0] got [$];
    int issued;
    bit acc;
    addrs[0] = BASE; addrs[1] = BASE + 16; addrs[2] = BASE + 24;
    expv[0] = 64'h1000; expv[1] = 64'hAB; expv[2] = 64'hDDDD_0003;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[0];
    step();
    req_addr = addrs[1];
    for (int c = 0; c < 5; c++) begin
      checks++; if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_data[0] !== expv[0]) begin
        errors++; $display("FAIL bp_hold c%0d got rdy %b v %b %h exp rdy 0 v 1 %h", c, req_ready[0], rsp_valid[0], rsp_data[0], expv[0]); end
      step();
    end
    rsp_ready = 1'b1;
    issued = 1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      req_valid = (issued < 3);
      req_addr  = addrs[(issued < 3) ? issued : 0];
      acc = req_valid && (!m_rsp_valid || rsp_ready);
      if (rsp_valid[0] && rsp_ready) got.push_back(rsp_data[0]);
      step();
      if (acc) issued++;
    end
    req_valid = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL bp_order%0d got %h exp %h", i, got[i], expv[i]); end
    end
  endtask

  task automatic test_race();
    rsp_ready = 1'b1; core_idle = 1'b0;
    do_req(1'b1, BASE + 32, 64'h0);
    checks++; if (pend[1] !== 1'b1 || cfg[1][DW +: DW] !== 64'hBBBB_0001) begin
      errors++; $display("FAIL race_pre got pend %b r1 %h exp pend 1 r1 bbbb0001", pend[1], cfg[1][DW +: DW]); end
    core_idle = 1'b1;
    do_req(1'b1, BASE + 8, 64'h55);
    checks++; if (cfg[1][DW +: DW] !== 64'h77 || pend[1] !== 1'b0) begin
      errors++; $display("FAIL race_excluded got r1 %h pend %b exp r1 77 pend 0", cfg[1][DW +: DW], pend[1]); end
    checks++; if (cfg[0][DW +: DW] !== 64'hBBBB_0001 || rsp_err[0] !== 1'b1) begin
      errors++; $display("FAIL race_ro got r1 %h e%b exp r1 bbbb0001 e1", cfg[0][DW +: DW], rsp_err[0]); end
    do_req(1'b1, BASE + 32, 64'h0);
    step();
    checks++; if (cfg[1][DW +: DW] !== 64'h55) begin errors++; $display("FAIL race_next_commit got %h exp 55", cfg[1][DW +: DW]); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (cfg[k] !== m_cfg(k)) begin errors++; $display("FAIL race_cfg inst%0d got %h exp %h", k, cfg[k], m_cfg(k)); end
    end
    core_idle = 1'b0;
  endtask

  task automatic test_double_commit();
    core_idle = 1'b0;
    do_req(1'b1, BASE + 32, 64'h0);
    do_req(1'b0, BASE + 32, 64'h0);
    checks++; if (rsp_data[0] !== 64'd1 || rsp_err[0] !== 1'b0) begin errors++; $display("FAIL dc_read1 got %h e%b exp 1 e0", rsp_data[0], rsp_err[0]); end
    do_req(1'b1, BASE + 32, 64'h0);
    checks++; if (rsp_err[0] !== 1'b0 || pend[0] !== 1'b1) begin errors++; $display("FAIL dc_second got e%b pend %b exp e0 pend 1", rsp_err[0], pend[0]); end
    do_req(1'b1, BASE + 24, 64'h3C);
    core_idle = 1'b1;
    step();
    checks++; if (pend[0] !== 1'b0 || cfg[0][3*DW +: DW] !== 64'h3C) begin
      errors++; $display("FAIL dc_apply got pend %b r3 %h exp pend 0 r3 3c", pend[0], cfg[0][3*DW +: DW]); end
    do_req(1'b1, BASE + 24, 64'h99);
    repeat (3) step();
    checks++; if (pend[0] !== 1'b0 || cfg[0][3*DW +: DW] !== 64'h3C) begin
      errors++; $display("FAIL dc_single_apply got pend %b r3 %h exp pend 0 r3 3c", pend[0], cfg[0][3*DW +: DW]); end
    do_req(1'b0, BASE + 32, 64'h0);
    checks++; if (rsp_data[0] !== 64'd0) begin errors++; $display("FAIL dc_read0 got %h exp 0", rsp_data[0]); end
    core_idle = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 6)       req_addr = BASE + 8 * $urandom_range(0, 3);
      else if (sel == 6) req_addr = BASE + 32;
      else if (sel == 7) req_addr = BASE + 8 * $urandom_range(0, 5) + $urandom_range(1, 7);
      else if (sel == 8) req_addr = BASE - $urandom_range(1, 64);
      else               req_addr = BASE + 8 * $urandom_range(5, 20);
      req_data  = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      core_idle = ($urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++; if (req_ready[k] !== (!m_rsp_valid || rsp_ready)) begin
          errors++; $display("FAIL rnd_ready n%0d inst%0d got %b exp %b", n, k, req_ready[k], !m_rsp_valid || rsp_ready); end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        checks++; if (rsp_valid[k] !== m_rsp_valid) begin
          errors++; $display("FAIL rnd_valid n%0d inst%0d got %b exp %b", n, k, rsp_valid[k], m_rsp_valid); end
        if (m_rsp_valid) begin
          checks++; if (rsp_data[k] !== m_rsp_data[k] || rsp_err[k] !== m_rsp_err[k]) begin
            errors++; $display("FAIL rnd_rsp n%0d inst%0d got %h e%b exp %h e%b", n, k, rsp_data[k], rsp_err[k], m_rsp_data[k], m_rsp_err[k]); end
        end
        checks++; if (pend[k] !== m_pend || cfg[k] !== m_cfg(k)) begin
          errors++; $display("FAIL rnd_state n%0d inst%0d got pend %b cfg %h exp pend %b cfg %h", n, k, pend[k], cfg[k], m_pend, m_cfg(k)); end
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_errors();
    test_backpressure();
    test_race();
    test_double_commit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
